// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and nibble width.
package adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_bit4adder.sv
// Four-bit ripple stage shared by every nibble of the serial adder.
module bit4adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_i,
    output logic [3:0] s,
    output logic       c_o
);

    // Plain 4-bit add with carry in/out.
    assign {c_o, s} = {1'b0, x} + {1'b0, y} + {4'b0000, c_i};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: accepts operands over valid/ready, adds one
// nibble per clock through a single bit4adder (LSB first), and presents a
// registered sum, carry and two's-complement overflow over valid/ready.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_o,
    output logic             ovf
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic               r_in_ready;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_s;
    logic               r_co;
    logic               r_ovf;

    logic [IDX_W+1:0]   w_lo;
    logic [3:0]         w_sum;
    logic               w_cout;
    logic               w_accept;
    logic               w_last;

    // Bit offset of the active nibble (idx * 4).
    assign w_lo     = {r_idx, 2'b00};
    assign w_accept = (r_state == IDLE) && r_in_ready && in_valid;
    assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));

    bit4adder u_bit4adder (
        .x   (r_x[w_lo +: NIBBLE_W]),
        .y   (r_y[w_lo +: NIBBLE_W]),
        .c_i (r_carry),
        .s   (w_sum),
        .c_o (w_cout)
    );

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register; in_ready is registered so it reads 0 throughout reset
    // and rises on the first edge that lands in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == IDLE);
        end
    end

    // Operand capture, per-nibble accumulation and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_carry <= c_i;
                        r_idx   <= '0;
                        r_s     <= '0;
                        r_co    <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                RUN: begin
                    r_s[w_lo +: NIBBLE_W] <= w_sum;
                    r_carry               <= w_cout;
                    r_idx                 <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_co  <= w_cout;
                        r_ovf <= (r_x[WIDTH-1] == r_y[WIDTH-1]) && (w_sum[3] != r_x[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == DONE);
    assign s         = r_s;
    assign c_o       = r_co;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        c_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] s;
    logic        c_o;
    logic        ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .c_i       (c_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_o       (c_o),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Single operation with out_ready high; latency counts the acceptance edge.
    task automatic do_op(input string name, input logic [15:0] ax, input logic [15:0] ay,
                         input logic aci, input logic [15:0] es, input logic eco, input logic eovf);
        int edges;
        int n;
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_wait in_ready=%b want 1", name, in_ready); end
        out_ready = 1'b1;
        x = ax; y = ay; c_i = aci; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        x = 16'hDEAD; y = 16'hBEEF; c_i = ~aci;
        edges = 1;
        while (!out_valid && edges < 20) begin step(); edges++; end
        total++;
        if (edges !== 5) begin bad++; $display("FAIL %s_latency edges=%0d want 5", name, edges); end
        total++;
        if (s !== es) begin bad++; $display("FAIL %s_s got=%h want=%h", name, s, es); end
        total++;
        if (c_o !== eco) begin bad++; $display("FAIL %s_co got=%b want=%b", name, c_o, eco); end
        total++;
        if (ovf !== eovf) begin bad++; $display("FAIL %s_ovf got=%b want=%b", name, ovf, eovf); end
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL %s_release out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        step(); step();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_hs in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
        end
        total++;
        if (s !== 16'h0000 || c_o !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("FAIL reset_out s=%h c_o=%b ovf=%b want 0000/0/0", s, c_o, ovf);
        end
        rst = 1'b0;
        step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_idle in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        do_op("basic",  16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("ovf",    16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        x = 16'h1234; y = 16'h1111; c_i = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_done out_valid=%b want 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            x = 16'h0F0F ^ 16'(i); y = 16'hF0F0 + 16'(i); c_i = ~i[0];
            step();
            total++;
            if (s !== 16'h2345 || c_o !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold%0d s=%h c_o=%b ovf=%b in_ready=%b out_valid=%b want 2345/0/0/0/1",
                         i, s, c_o, ovf, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        x = 16'h1234; y = 16'h1111; c_i = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        #2 rst = 1'b1;
        #1;
        total++;
        if (s !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL midrst s=%h out_valid=%b in_ready=%b want 0000/0/0", s, out_valid, in_ready);
        end
        step();
        rst = 1'b0;
        step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_idle in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        do_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    endtask

    // in_valid and out_ready held high; results expected every 6 cycles.
    task automatic test_back_to_back();
        logic [15:0] vx  [5] = '{16'h0001, 16'h8000, 16'hABCD, 16'h4000, 16'hFFFF};
        logic [15:0] vy  [5] = '{16'h0002, 16'h8000, 16'h1234, 16'h4000, 16'hFFFF};
        logic        vci [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] es  [5] = '{16'h0003, 16'h0000, 16'hBE02, 16'h8000, 16'hFFFF};
        logic        eco [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        eov [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int prev_acc;
        int acc;
        int n;
        prev_acc = -1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!in_ready && n < 20) begin step(); n++; end
            x = vx[k]; y = vy[k]; c_i = vci[k];
            step();
            acc = cyc;
            if (prev_acc >= 0) begin
                total++;
                if (acc - prev_acc !== 6) begin
                    bad++; $display("FAIL b2b%0d_period got=%0d want=6", k, acc - prev_acc);
                end
            end
            prev_acc = acc;
            n = 0;
            while (!out_valid && n < 20) begin step(); n++; end
            total++;
            if (s !== es[k] || c_o !== eco[k] || ovf !== eov[k]) begin
                bad++;
                $display("FAIL b2b%0d_result s=%h c_o=%b ovf=%b want %h/%b/%b",
                         k, s, c_o, ovf, es[k], eco[k], eov[k]);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
